uart_tx_buffer: RTL

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_tx_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// First-word-fall-through transmit buffer between a byte producer and a UART transmitter.
// Optional macro UART_TX_BUF_OVF_CNT_EN enables the saturating dropped-write counter on o_ovf_cnt.
module uart_tx_buffer #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_DEPTH_LOG2 = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_DATA_WIDTH-1:0] i_wr_data,
  input  logic                    i_wr_en,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [P_DEPTH_LOG2:0]   o_level,
  output logic [P_DATA_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_overflow,
  output logic [7:0]              o_ovf_cnt
);

  localparam int DEPTH = 1 << P_DEPTH_LOG2;
  localparam logic [P_DEPTH_LOG2:0] DEPTH_LEVEL = (P_DEPTH_LOG2+1)'(DEPTH);

  logic [P_DATA_WIDTH-1:0] mem [DEPTH];

  logic [P_DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [P_DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [P_DEPTH_LOG2-1:0] rd_ptr_next;
  logic [P_DEPTH_LOG2:0]   level_reg;
  logic [P_DEPTH_LOG2:0]   level_next;
  logic                    full_reg;
  logic                    empty_reg;
  logic                    valid_reg;
  logic                    overflow_reg;
  logic [P_DATA_WIDTH-1:0] data_reg;

  logic wr_accept;
  logic wr_drop;
  logic pop;
  logic bypass;

  // Acceptance uses the registered full flag, so a pop in the same cycle never frees a slot early.
  assign wr_accept = i_wr_en & ~full_reg;
  assign wr_drop   = i_wr_en & full_reg;
  assign pop       = valid_reg & i_tx_ready;

  always_comb begin
    rd_ptr_next = rd_ptr_reg + P_DEPTH_LOG2'(pop);
    level_next  = level_reg + (P_DEPTH_LOG2+1)'(wr_accept) - (P_DEPTH_LOG2+1)'(pop);
    // The incoming word becomes the head when the buffer drains to zero this cycle.
    bypass      = wr_accept && (wr_ptr_reg == rd_ptr_next);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_accept) begin
      mem[wr_ptr_reg] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      data_reg     <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      full_reg     <= (level_next == DEPTH_LEVEL);
      empty_reg    <= (level_next == '0);
      valid_reg    <= (level_next != '0);
      overflow_reg <= overflow_reg | wr_drop;
      // Head register is a registered read of the next head slot, with write bypass.
      if (level_next != '0) begin
        data_reg <= bypass ? i_wr_data : mem[rd_ptr_next];
      end
    end
  end

`ifdef UART_TX_BUF_OVF_CNT_EN
  logic [7:0] ovf_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_cnt_reg <= 8'd0;
    end else if (wr_drop && (ovf_cnt_reg != 8'hFF)) begin
      ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
    end
  end

  assign o_ovf_cnt = ovf_cnt_reg;
`else
  assign o_ovf_cnt = 8'd0;
`endif

  assign o_full     = full_reg;
  assign o_empty    = empty_reg;
  assign o_level    = level_reg;
  assign o_tx_data  = data_reg;
  assign o_tx_valid = valid_reg;
  assign o_overflow = overflow_reg;

endmodule
